axi_reg_slice: RTL and testbench
================================

// Module: axi_reg_slice
// PURPOSE
// - Parametrised AXI3 register slice: one independent valid/ready pipeline stage per channel (AW, W, B, AR, R).
// - Sits between an axi_if.Slave (upstream master) and an axi_if.Master (downstream slave) to break timing paths.
// - Mode is selected per channel: bypass, forward-registered or full skid. Widths follow axi_if.
// - Payload is never reordered, dropped or modified.
// PARAMETERS
// - ID_WIDTH    AXI_ID_W    ID width on all channels
// - ADDR_WIDTH  AXI_ADDR_W  AWADDR/ARADDR width
// - DATA_WIDTH  AXI_DATA_W  WDATA/RDATA width; STRB_WIDTH = DATA_WIDTH/8
// - AW_MODE     SLICE_FULL  slice_mode_e for the AW channel
// - W_MODE      SLICE_FULL  slice_mode_e for the W channel
// - B_MODE      SLICE_FWD   slice_mode_e for the B channel
// - AR_MODE     SLICE_FULL  slice_mode_e for the AR channel
// - R_MODE      SLICE_FULL  slice_mode_e for the R channel
// PORTS
// - ACLK     in   1    single clock for all channels
// - ARESETn  in   1    asynchronous, active-low reset
// - s_axi    if   axi_if.Slave   upstream side; the master drives AW/W/AR, the slice returns B/R
// - m_axi    if   axi_if.Master  downstream side; the slice drives AW/W/AR, the slave returns B/R
// - stall_cnt out 5x16 per-channel stall counters; present only with APB2AXI_SLICE_STATS_EN
// BEHAVIOUR
// - Reset (ARESETn=0, async): all output VALIDs = 0, all output READYs = 0, buffers emptied, payload regs = 0.
//   - First acceptance is possible on the first ACLK edge after release.
// - Payload per channel, with fields concatenated in the axi_if declaration order:
//   - AW/AR = ID + ADDR + 4 + 3 + 2 + 1 + 4 + 3
//   - W     = DATA + STRB + 1
//   - B     = ID + 2
//   - R     = ID + DATA + 2 + 1
// - Handshake rules:
//   - A transfer occurs on a rising edge with VALID && READY.
//   - Once output VALID is high, it and its payload hold until the matching READY is seen.
// - SLICE_BYPASS: combinational wires; latency 0; no state.
// - SLICE_FWD: one data register; latency 1 cycle.
//   - src_ready = !vld_q || dst_ready (combinational path from dst_ready).
//   - Simultaneous pop and push while full: the register reloads in the same cycle; full throughput.
// - SLICE_FULL: 2-entry skid buffer; latency 1 cycle; both VALID and READY are registered (no combinational path).
//   - count in {0,1,2}; src_ready = (count<2), registered.
//   - Push and pop in the same cycle: count is unchanged and order is kept (head entry pops, new entry goes to tail).
//   - count==2: src_ready=0; upstream stalls with no data loss.
//   - count==0: dst_valid=0; a push becomes visible the next cycle.
//   - Sustained throughput is 1 beat/cycle under a continuous dst_ready=1.
// - Channels are fully independent. No AW/W ordering is enforced; WLAST and RLAST pass through untouched.
// - Reset mid-burst: all in-flight beats are discarded. The upstream master must also be in reset.
// CONFIGURATION
// - APB2AXI_SLICE_STATS_EN defined:
//   - Per channel, a 16-bit saturating counter increments each cycle the output side has VALID=1 && READY=0.
//   - Counters clear on reset and saturate at 16'hFFFF. Exported on stall_cnt as [0]=AW,[1]=W,[2]=B,[3]=AR,[4]=R.
// - APB2AXI_SLICE_STATS_EN undefined: no counters and no stall_cnt port; datapath behaviour is identical.
// STRUCTURE
// - apb2axi_pkg:
//   - typedef enum logic [1:0] {SLICE_BYPASS=0, SLICE_FWD=1, SLICE_FULL=2} slice_mode_e
//   - localparams for the AW/W/B/AR/R payload widths, derived from the AXI_* constants
// - Sub-module axi_skid_buf #(WIDTH, MODE):
//   - ports ACLK, ARESETn, src_valid/src_ready/src_data, dst_valid/dst_ready/dst_data
//   - instantiated 5x: AW, W, AR forward; B, R reverse
// - Top level holds only pack/unpack logic and the optional stall counters.
// TESTING
// - FULL, single AW: AWADDR=0x1000, AWLEN=3, AWID=2 sent -> m_axi AWVALID=1 one cycle later with identical fields; s_axi AWREADY stays 1.
// - FULL, back-pressure:
//   - Stimulus: m_axi WREADY=0, 4 W beats offered (WDATA=0xA0..0xA3).
//   - Response: 2 beats accepted, then s_axi WREADY=0; after WREADY=1, beats exit in order A0..A3 with no gap.
// - Throughput: 16-beat R burst (RLAST on beat 16) with all READYs high -> 16 beats in 16 consecutive cycles, RLAST only on the last.
// - FWD B channel: BID=5, BRESP=2'b10 -> s_axi BVALID one cycle later; push and pop in the same cycle holds throughput at 1/cycle.
// - Async reset: ARESETn asserted mid-burst with count==2 -> all VALIDs 0 immediately; after release, no stale beat appears.
// - STATS_EN: AR held stalled 10 cycles -> stall_cnt[3]==10; forced 70000 stall cycles -> stall_cnt[3]==16'hFFFF.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared types and width helpers for the AXI3 register slice.
package apb2axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam int NUM_CH      = 5;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;

  // AW/AR: id + addr + len(4) + size(3) + burst(2) + lock(1) + cache(4) + prot(3)
  function automatic int ax_payload_w(int id_w, int addr_w);
    return id_w + addr_w + 17;
  endfunction

  function automatic int w_payload_w(int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int b_payload_w(int id_w);
    return id_w + 2;
  endfunction

  function automatic int r_payload_w(int id_w, int data_w);
    return id_w + data_w + 3;
  endfunction

  localparam int AXI_AX_PAYLOAD_W = ax_payload_w(AXI_ID_W, AXI_ADDR_W);
  localparam int AXI_W_PAYLOAD_W  = w_payload_w(AXI_DATA_W);
  localparam int AXI_B_PAYLOAD_W  = b_payload_w(AXI_ID_W);
  localparam int AXI_R_PAYLOAD_W  = r_payload_w(AXI_ID_W, AXI_DATA_W);

endpackage

// File: rtl/axi_if.sv
// AXI3 bundle used on both sides of the register slice.
interface axi_if #(
  parameter int ID_W   = apb2axi_pkg::AXI_ID_W,
  parameter int ADDR_W = apb2axi_pkg::AXI_ADDR_W,
  parameter int DATA_W = apb2axi_pkg::AXI_DATA_W
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport Master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport Slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_skid_buf.sv
// One valid/ready pipeline stage: bypass wires, forward register, or 2-entry skid buffer.
module axi_skid_buf import apb2axi_pkg::*; #(
  parameter int          WIDTH = 8,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data
);

  generate
    if (MODE == SLICE_BYPASS) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = ACLK ^ ARESETn;
      assign dst_valid = src_valid;
      assign dst_data  = src_data;
      assign src_ready = dst_ready;
    end else if (MODE == SLICE_FWD) begin : g_fwd
      logic             vld_reg;
      logic [WIDTH-1:0] data_reg;

      // Ready is held low while in reset so nothing is accepted before release.
      assign src_ready = ARESETn && (!vld_reg || dst_ready);
      assign dst_valid = vld_reg;
      assign dst_data  = data_reg;

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          vld_reg  <= 1'b0;
          data_reg <= '0;
        end else if (src_valid && src_ready) begin
          vld_reg  <= 1'b1;
          data_reg <= src_data;
        end else if (dst_ready) begin
          vld_reg  <= 1'b0;
        end
      end
    end else begin : g_full
      logic [WIDTH-1:0] mem_reg [2];
      logic             wr_ptr_reg;
      logic             rd_ptr_reg;
      logic [1:0]       count_reg;
      logic [1:0]       count_next;
      logic             rdy_reg;
      logic             push;
      logic             pop;

      // rdy_reg resets high so the first edge after release can accept.
      assign src_ready = rdy_reg && ARESETn;
      assign dst_valid = (count_reg != 2'd0);
      assign dst_data  = mem_reg[rd_ptr_reg];
      assign push      = src_valid && src_ready;
      assign pop       = dst_valid && dst_ready;

      always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
          count_next = count_reg + 2'd1;
        end else if (!push && pop) begin
          count_next = count_reg - 2'd1;
        end
      end

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          mem_reg[0] <= '0;
          mem_reg[1] <= '0;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          count_reg  <= 2'd0;
          rdy_reg    <= 1'b1;
        end else begin
          if (push) begin
            mem_reg[wr_ptr_reg] <= src_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
          end
          if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
          end
          count_reg <= count_next;
          rdy_reg   <= (count_next != 2'd2);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axi_reg_slice.sv
// AXI3 register slice: one independent stage per channel. Optional stall
// counters are built when APB2AXI_SLICE_STATS_EN is defined.
module axi_reg_slice import apb2axi_pkg::*; #(
  parameter int          ID_WIDTH   = AXI_ID_W,
  parameter int          ADDR_WIDTH = AXI_ADDR_W,
  parameter int          DATA_WIDTH = AXI_DATA_W,
  parameter slice_mode_e AW_MODE    = SLICE_FULL,
  parameter slice_mode_e W_MODE     = SLICE_FULL,
  parameter slice_mode_e B_MODE     = SLICE_FWD,
  parameter slice_mode_e AR_MODE    = SLICE_FULL,
  parameter slice_mode_e R_MODE     = SLICE_FULL
) (
  input  logic  ACLK,
  input  logic  ARESETn,
  axi_if.Slave  s_axi,
  axi_if.Master m_axi
`ifdef APB2AXI_SLICE_STATS_EN
  ,
  output logic [NUM_CH-1:0][STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int AX_W = ax_payload_w(ID_WIDTH, ADDR_WIDTH);
  localparam int W_W  = w_payload_w(DATA_WIDTH);
  localparam int B_W  = b_payload_w(ID_WIDTH);
  localparam int R_W  = r_payload_w(ID_WIDTH, DATA_WIDTH);

  logic [AX_W-1:0] aw_src, aw_dst, ar_src, ar_dst;
  logic [W_W-1:0]  w_src, w_dst;
  logic [B_W-1:0]  b_src, b_dst;
  logic [R_W-1:0]  r_src, r_dst;

  assign aw_src = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize,
                   s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot};
  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize,
          m_axi.awburst, m_axi.awlock, m_axi.awcache, m_axi.awprot} = aw_dst;

  assign w_src = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_dst;

  assign ar_src = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize,
                   s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot};
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize,
          m_axi.arburst, m_axi.arlock, m_axi.arcache, m_axi.arprot} = ar_dst;

  // Response channels run downstream-to-upstream.
  assign b_src = {m_axi.bid, m_axi.bresp};
  assign {s_axi.bid, s_axi.bresp} = b_dst;

  assign r_src = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast};
  assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = r_dst;

  axi_skid_buf #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .src_valid(s_axi.awvalid), .src_ready(s_axi.awready), .src_data(aw_src),
    .dst_valid(m_axi.awvalid), .dst_ready(m_axi.awready), .dst_data(aw_dst)
  );

  axi_skid_buf #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .src_valid(s_axi.wvalid), .src_ready(s_axi.wready), .src_data(w_src),
    .dst_valid(m_axi.wvalid), .dst_ready(m_axi.wready), .dst_data(w_dst)
  );

  axi_skid_buf #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .src_valid(m_axi.bvalid), .src_ready(m_axi.bready), .src_data(b_src),
    .dst_valid(s_axi.bvalid), .dst_ready(s_axi.bready), .dst_data(b_dst)
  );

  axi_skid_buf #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .src_valid(s_axi.arvalid), .src_ready(s_axi.arready), .src_data(ar_src),
    .dst_valid(m_axi.arvalid), .dst_ready(m_axi.arready), .dst_data(ar_dst)
  );

  axi_skid_buf #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .src_valid(m_axi.rvalid), .src_ready(m_axi.rready), .src_data(r_src),
    .dst_valid(s_axi.rvalid), .dst_ready(s_axi.rready), .dst_data(r_dst)
  );

`ifdef APB2AXI_SLICE_STATS_EN
  localparam logic [STALL_CNT_W-1:0] STALL_SAT = '1;

  logic [NUM_CH-1:0] stall_evt;

  // A stall is the output side of a channel offering data that is not taken.
  assign stall_evt = {s_axi.rvalid  && !s_axi.rready,
                      m_axi.arvalid && !m_axi.arready,
                      s_axi.bvalid  && !s_axi.bready,
                      m_axi.wvalid  && !m_axi.wready,
                      m_axi.awvalid && !m_axi.awready};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stall
      logic [STALL_CNT_W-1:0] cnt_reg;

      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          cnt_reg <= '0;
        end else if (stall_evt[gi] && (cnt_reg != STALL_SAT)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign stall_cnt[gi] = cnt_reg;
    end
  endgenerate
`else
  // Statistics compiled out; the datapath is unaffected.
`endif

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed self-checking bench for axi_reg_slice (default channel modes).
module tb_axi_reg_slice;
  import apb2axi_pkg::*;

  logic ACLK;
  logic ARESETn;
  int   n_vec;
  int   n_err;

  axi_if #(.ID_W(AXI_ID_W), .ADDR_W(AXI_ADDR_W), .DATA_W(AXI_DATA_W)) s_if ();
  axi_if #(.ID_W(AXI_ID_W), .ADDR_W(AXI_ADDR_W), .DATA_W(AXI_DATA_W)) m_if ();

`ifdef APB2AXI_SLICE_STATS_EN
  logic [4:0][15:0] stall_cnt;
`endif

  axi_reg_slice #(
    .ID_WIDTH(AXI_ID_W), .ADDR_WIDTH(AXI_ADDR_W), .DATA_WIDTH(AXI_DATA_W)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .s_axi(s_if),
    .m_axi(m_if)
`ifdef APB2AXI_SLICE_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0;
    s_if.awburst = '0; s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0;
    s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b0;
    s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
    s_if.arburst = '0; s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0;
    s_if.arvalid = 1'b0;
    s_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
    m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
    #2;
    n_vec++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_valids: got %b expected 00000",
               {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid});
    end
    n_vec++;
    if ({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_readies: got %b expected 00000",
               {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready});
    end
    n_vec++;
    if (m_if.awaddr !== 32'h0 || s_if.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_payload: got awaddr=%h rdata=%h expected 0", m_if.awaddr, s_if.rdata);
    end
    #10;
    ARESETn = 1'b1;
    #1;
    n_vec++;
    if ({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} !== 5'b11111) begin
      n_err++;
      $display("FAIL release_readies: got %b expected 11111",
               {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready});
    end
    $display("reset: %0d vectors so far", n_vec);
  endtask

  task automatic test_aw_single();
    m_if.awready = 1'b1;
    s_if.awvalid = 1'b1; s_if.awid = 4'd2; s_if.awaddr = 32'h1000; s_if.awlen = 4'd3;
    s_if.awsize = 3'd2; s_if.awburst = 2'b01; s_if.awlock = 1'b0; s_if.awcache = 4'h3; s_if.awprot = 3'd1;
    #1;
    n_vec++;
    if (s_if.awready !== 1'b1 || m_if.awvalid !== 1'b0) begin
      n_err++;
      $display("FAIL aw_first_accept: got awready=%b m_awvalid=%b expected 1/0", s_if.awready, m_if.awvalid);
    end
    tick();
    s_if.awvalid = 1'b0;
    #1;
    n_vec++;
    if (m_if.awvalid !== 1'b1 || s_if.awready !== 1'b1) begin
      n_err++;
      $display("FAIL aw_latency: got m_awvalid=%b awready=%b expected 1/1", m_if.awvalid, s_if.awready);
    end
    n_vec++;
    if (m_if.awid !== 4'd2 || m_if.awaddr !== 32'h1000 || m_if.awlen !== 4'd3 || m_if.awsize !== 3'd2 ||
        m_if.awburst !== 2'b01 || m_if.awlock !== 1'b0 || m_if.awcache !== 4'h3 || m_if.awprot !== 3'd1) begin
      n_err++;
      $display("FAIL aw_fields: got id=%0d addr=%h len=%0d size=%0d burst=%0d cache=%0d prot=%0d expected 2 1000 3 2 1 3 1",
               m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awcache, m_if.awprot);
    end
    tick();
    #1;
    n_vec++;
    if (m_if.awvalid !== 1'b0) begin
      n_err++;
      $display("FAIL aw_drain: got m_awvalid=%b expected 0", m_if.awvalid);
    end
    m_if.awready = 1'b0;
    $display("aw_single: addr=%h id=%0d len=%0d", m_if.awaddr, m_if.awid, m_if.awlen);
  endtask

  task automatic test_w_backpressure();
    int idx;
    int out_n;
    int first;
    int gap;
    logic acc;
    m_if.wready = 1'b0;
    s_if.wstrb = 4'hF;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      s_if.wvalid = 1'b1;
      s_if.wdata  = 32'(32'hA0 + idx);
      s_if.wlast  = (idx == 3);
      #1;
      n_vec++;
      if (s_if.wready !== (c < 2)) begin
        n_err++;
        $display("FAIL w_fill_ready: cycle %0d got wready=%b expected %b", c, s_if.wready, (c < 2));
      end
      acc = s_if.wvalid && s_if.wready;
      tick();
      if (acc) idx++;
    end
    n_vec++;
    if (m_if.wvalid !== 1'b1 || m_if.wdata !== 32'hA0) begin
      n_err++;
      $display("FAIL w_head_hold: got wvalid=%b wdata=%h expected 1 a0", m_if.wvalid, m_if.wdata);
    end
    m_if.wready = 1'b1;
    out_n = 0; first = -1; gap = 0;
    for (int c = 0; c < 10; c++) begin
      s_if.wvalid = (idx < 4);
      s_if.wdata  = 32'(32'hA0 + idx);
      s_if.wlast  = (idx == 3);
      #1;
      if (m_if.wvalid && m_if.wready) begin
        n_vec++;
        if (m_if.wdata !== 32'(32'hA0 + out_n) || m_if.wlast !== (out_n == 3)) begin
          n_err++;
          $display("FAIL w_order: beat %0d got wdata=%h wlast=%b expected %h %b",
                   out_n, m_if.wdata, m_if.wlast, 32'(32'hA0 + out_n), (out_n == 3));
        end
        if (first < 0) first = c;
        else if (c != first + out_n) gap = 1;
        out_n++;
      end
      acc = s_if.wvalid && s_if.wready;
      tick();
      if (acc) idx++;
    end
    s_if.wvalid = 1'b0;
    m_if.wready = 1'b0;
    n_vec++;
    if (out_n !== 4 || gap !== 0) begin
      n_err++;
      $display("FAIL w_drain: got beats=%0d gap=%0d expected 4 0", out_n, gap);
    end
    $display("w_backpressure: %0d beats out", out_n);
  endtask

  task automatic test_b_fwd();
    int idx;
    int out_n;
    int first;
    int gap;
    logic acc;
    logic [1:0] exp_resp;
    s_if.bready = 1'b0;
    m_if.bvalid = 1'b1; m_if.bid = 4'd5; m_if.bresp = 2'b10;
    #1;
    n_vec++;
    if (m_if.bready !== 1'b1 || s_if.bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b_accept: got bready=%b s_bvalid=%b expected 1/0", m_if.bready, s_if.bvalid);
    end
    tick();
    m_if.bvalid = 1'b0;
    #1;
    n_vec++;
    if (s_if.bvalid !== 1'b1 || s_if.bid !== 4'd5 || s_if.bresp !== 2'b10) begin
      n_err++;
      $display("FAIL b_latency: got bvalid=%b bid=%0d bresp=%b expected 1 5 10", s_if.bvalid, s_if.bid, s_if.bresp);
    end
    n_vec++;
    if (m_if.bready !== 1'b0) begin
      n_err++;
      $display("FAIL b_full_ready: got bready=%b expected 0", m_if.bready);
    end
    s_if.bready = 1'b1;
    idx = 0; out_n = 0; first = -1; gap = 0;
    for (int c = 0; c < 8; c++) begin
      m_if.bvalid = (idx < 4);
      m_if.bid    = 4'(6 + idx);
      m_if.bresp  = 2'(idx);
      #1;
      if (s_if.bvalid && s_if.bready) begin
        exp_resp = (out_n == 0) ? 2'b10 : 2'(out_n - 1);
        n_vec++;
        if (s_if.bid !== 4'(5 + out_n) || s_if.bresp !== exp_resp) begin
          n_err++;
          $display("FAIL b_stream: beat %0d got bid=%0d bresp=%b expected %0d %b",
                   out_n, s_if.bid, s_if.bresp, 5 + out_n, exp_resp);
        end
        if (first < 0) first = c;
        else if (c != first + out_n) gap = 1;
        out_n++;
      end
      acc = m_if.bvalid && m_if.bready;
      tick();
      if (acc) idx++;
    end
    m_if.bvalid = 1'b0;
    s_if.bready = 1'b0;
    n_vec++;
    if (out_n !== 5 || gap !== 0) begin
      n_err++;
      $display("FAIL b_throughput: got beats=%0d gap=%0d expected 5 0", out_n, gap);
    end
    $display("b_fwd: %0d responses out", out_n);
  endtask

  task automatic test_r_throughput();
    int idx;
    int out_n;
    int first;
    int gap;
    logic acc;
    s_if.rready = 1'b1;
    idx = 0; out_n = 0; first = -1; gap = 0;
    for (int c = 0; c < 20; c++) begin
      m_if.rvalid = (idx < 16);
      m_if.rid    = 4'd3;
      m_if.rdata  = 32'(32'h100 + idx);
      m_if.rresp  = 2'b00;
      m_if.rlast  = (idx == 15);
      #1;
      if (s_if.rvalid && s_if.rready) begin
        n_vec++;
        if (s_if.rdata !== 32'(32'h100 + out_n) || s_if.rlast !== (out_n == 15) || s_if.rid !== 4'd3) begin
          n_err++;
          $display("FAIL r_beat: beat %0d got rdata=%h rlast=%b rid=%0d expected %h %b 3",
                   out_n, s_if.rdata, s_if.rlast, s_if.rid, 32'(32'h100 + out_n), (out_n == 15));
        end
        if (first < 0) first = c;
        else if (c != first + out_n) gap = 1;
        out_n++;
      end
      acc = m_if.rvalid && m_if.rready;
      tick();
      if (acc) idx++;
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    s_if.rready = 1'b0;
    n_vec++;
    if (out_n !== 16 || gap !== 0 || first !== 1) begin
      n_err++;
      $display("FAIL r_throughput: got beats=%0d gap=%0d first=%0d expected 16 0 1", out_n, gap, first);
    end
    $display("r_throughput: %0d beats, first at cycle %0d", out_n, first);
  endtask

  task automatic test_async_reset();
    int stale;
    m_if.arready = 1'b0;
    s_if.arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.araddr = 32'(32'h2000 + 4 * i);
      tick();
    end
    #1;
    n_vec++;
    if (s_if.arready !== 1'b0 || m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h2000) begin
      n_err++;
      $display("FAIL ar_full: got arready=%b arvalid=%b araddr=%h expected 0 1 2000",
               s_if.arready, m_if.arvalid, m_if.araddr);
    end
    ARESETn = 1'b0;
    #1;
    n_vec++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid} !== 5'b0 || s_if.arready !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got valids=%b arready=%b expected 00000 0",
               {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}, s_if.arready);
    end
    s_if.arvalid = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    m_if.arready = 1'b1;
    #1;
    n_vec++;
    if (s_if.arready !== 1'b1) begin
      n_err++;
      $display("FAIL ar_release_ready: got arready=%b expected 1", s_if.arready);
    end
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m_if.arvalid !== 1'b0) stale++;
      tick();
    end
    n_vec++;
    if (stale !== 0) begin
      n_err++;
      $display("FAIL ar_stale: got %0d stale cycles expected 0", stale);
    end
    $display("async_reset: stale cycles %0d", stale);
  endtask

`ifdef APB2AXI_SLICE_STATS_EN
  task automatic test_stats();
    n_vec++;
    if (stall_cnt[3] !== 16'd0) begin
      n_err++;
      $display("FAIL stats_clear: got %0d expected 0", stall_cnt[3]);
    end
    m_if.arready = 1'b0;
    s_if.arvalid = 1'b1;
    s_if.araddr  = 32'h3000;
    tick();
    s_if.arvalid = 1'b0;
    repeat (10) tick();
    n_vec++;
    if (stall_cnt[3] !== 16'd10) begin
      n_err++;
      $display("FAIL stats_ar10: got %0d expected 10", stall_cnt[3]);
    end
    repeat (70000) tick();
    n_vec++;
    if (stall_cnt[3] !== 16'hFFFF) begin
      n_err++;
      $display("FAIL stats_sat: got %h expected ffff", stall_cnt[3]);
    end
    n_vec++;
    if (stall_cnt[0] !== 16'd0) begin
      n_err++;
      $display("FAIL stats_aw_idle: got %0d expected 0", stall_cnt[0]);
    end
    m_if.arready = 1'b1;
    tick();
    $display("stats: ar stall count %h", stall_cnt[3]);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_aw_single();
    test_w_backpressure();
    test_b_fwd();
    test_r_throughput();
    test_async_reset();
`ifdef APB2AXI_SLICE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
